// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants, tuser layout and parser state type.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

  // Byte offsets from the start of the Ethernet frame.
  localparam int OFF_ETHERTYPE = 12;
  localparam int OFF_VER_IHL   = 14;
  localparam int OFF_IP_PROTO  = 23;
  localparam int OFF_UDP_DPORT = 36;
  localparam int HDR_LEN       = 42;
  localparam int BEAT_BYTES    = 8;

  localparam int TUSER_ERR_BIT = 0;
  localparam int TUSER_TS_LSB  = 8;
  localparam int TUSER_TS_MSB  = 71;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_FLUSH,
    ST_DROP
  } parser_state_e;

  // Contiguous-from-bit-0 byte enable for n valid bytes (n <= 8).
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

  // Number of valid bytes in a beat.
  function automatic logic [3:0] keep_count(input logic [7:0] keep);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (keep[i]) c = c + 4'd1;
    end
    return c;
  endfunction

endpackage

// File: rtl/udp_rx_parser.sv
// UDP receive parser: checks Eth/IPv4/UDP headers, drops non-matching frames,
// strips the 42-byte header and re-aligns the payload to byte 0.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_HDR     | collecting beats 0-4, header fields latched, decide on beat 4
// ST_PAYLOAD | forwarding payload through the 6-byte holding register
// ST_FLUSH   | input stalled, emitting the held tail of the frame
// ST_DROP    | discarding the rest of a rejected frame
module udp_rx_parser
  import eth_pkg::*;
#(
  parameter int USER_WIDTH = 72,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           cfg_udp_port,
  input  logic [63:0]           s_axis_tdata,
  input  logic [7:0]            s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  frames_ok,
  output logic [CNT_WIDTH-1:0]  frames_drop,
  output logic [CNT_WIDTH-1:0]  frames_err
);

  localparam logic [2:0] BEAT_ETYPE  = 3'(OFF_ETHERTYPE / BEAT_BYTES);
  localparam logic [2:0] BEAT_VERIHL = 3'(OFF_VER_IHL / BEAT_BYTES);
  localparam logic [2:0] BEAT_PROTO  = 3'(OFF_IP_PROTO / BEAT_BYTES);
  localparam logic [2:0] BEAT_DPORT  = 3'(OFF_UDP_DPORT / BEAT_BYTES);
  localparam int LANE_ETYPE  = OFF_ETHERTYPE % BEAT_BYTES;
  localparam int LANE_VERIHL = OFF_VER_IHL % BEAT_BYTES;
  localparam int LANE_PROTO  = OFF_IP_PROTO % BEAT_BYTES;
  localparam int LANE_DPORT  = OFF_UDP_DPORT % BEAT_BYTES;

  parser_state_e state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [15:0] port_q, port_d;
  logic [15:0] etype_q, etype_d;
  logic [7:0]  verihl_q, verihl_d;
  logic [7:0]  proto_q, proto_d;
  logic [63:0] ts_q, ts_d;
  logic        first_q, first_d;
  logic [47:0] hold_q, hold_d;
  logic [7:0]  flush_keep_q, flush_keep_d;
  logic        flush_err_q, flush_err_d;

  logic                  m_tvalid_q, m_tvalid_d;
  logic [63:0]           m_tdata_q, m_tdata_d;
  logic [7:0]            m_tkeep_q, m_tkeep_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;

  logic [CNT_WIDTH-1:0] ok_q, ok_d, drop_q, drop_d, err_q, err_d;

  logic        out_free;
  logic        s_ready;
  logic        in_hs;
  logic [3:0]  n_last;
  logic        last_err;
  logic        hdr_ok;
  logic [15:0] dport_in;
  logic        drop_inc;
  logic        out_last_hs;
  logic        unused_tuser;

  assign unused_tuser = ^s_axis_tuser[7:1];

  // Next-state, realign datapath, output register load and counter updates.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    port_d       = port_q;
    etype_d      = etype_q;
    verihl_d     = verihl_q;
    proto_d      = proto_q;
    ts_d         = ts_q;
    first_d      = first_q;
    hold_d       = hold_q;
    flush_keep_d = flush_keep_q;
    flush_err_d  = flush_err_q;
    m_tvalid_d   = m_tvalid_q && !m_axis_tready;
    m_tdata_d    = m_tdata_q;
    m_tkeep_d    = m_tkeep_q;
    m_tlast_d    = m_tlast_q;
    m_tuser_d    = m_tuser_q;
    ok_d         = ok_q;
    drop_d       = drop_q;
    err_d        = err_q;
    drop_inc     = 1'b0;
    hdr_ok       = 1'b0;

    out_free = !m_tvalid_q || m_axis_tready;
    case (state_q)
      ST_PAYLOAD: s_ready = out_free;
      ST_FLUSH:   s_ready = 1'b0;
      default:    s_ready = 1'b1;
    endcase
    in_hs    = s_axis_tvalid && s_ready;
    n_last   = keep_count(s_axis_tkeep);
    last_err = s_axis_tlast && s_axis_tuser[TUSER_ERR_BIT];
    dport_in = {s_axis_tdata[8*LANE_DPORT +: 8], s_axis_tdata[8*(LANE_DPORT+1) +: 8]};

    case (state_q)
      ST_HDR: begin
        if (in_hs) begin
          if (beat_q == 3'd0) begin
            ts_d   = s_axis_tuser[TUSER_TS_MSB:TUSER_TS_LSB];
            port_d = cfg_udp_port;
          end
          if (beat_q == BEAT_ETYPE)
            etype_d = {s_axis_tdata[8*LANE_ETYPE +: 8], s_axis_tdata[8*(LANE_ETYPE+1) +: 8]};
          if (beat_q == BEAT_VERIHL)
            verihl_d = s_axis_tdata[8*LANE_VERIHL +: 8];
          if (beat_q == BEAT_PROTO)
            proto_d = s_axis_tdata[8*LANE_PROTO +: 8];

          hdr_ok = (etype_q == ETHERTYPE_IPV4) && (verihl_q == IPV4_VER_IHL) &&
                   (proto_q == IP_PROTO_UDP) && (dport_in == port_q);

          if (s_axis_tlast) begin
            drop_inc = 1'b1;
            beat_d   = 3'd0;
          end else if (beat_q == BEAT_DPORT) begin
            beat_d  = 3'd0;
            first_d = 1'b1;
            state_d = hdr_ok ? ST_PAYLOAD : ST_DROP;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (in_hs) begin
          hold_d  = s_axis_tdata[63:16];
          first_d = 1'b0;
          if (first_q) begin
            // Payload begins at lane 2 of this beat; nothing is held yet.
            if (s_axis_tlast) begin
              state_d = ST_HDR;
              if (n_last > 4'd2) begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = {16'h0, s_axis_tdata[63:16]};
                m_tkeep_d  = keep_mask(n_last - 4'd2);
                m_tlast_d  = 1'b1;
                m_tuser_d  = '0;
                m_tuser_d[TUSER_TS_MSB:TUSER_TS_LSB] = ts_q;
                m_tuser_d[TUSER_ERR_BIT] = last_err;
              end else begin
                drop_inc = 1'b1;
              end
            end
          end else begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = {s_axis_tdata[15:0], hold_q};
            m_tkeep_d  = 8'hFF;
            m_tlast_d  = 1'b0;
            m_tuser_d  = '0;
            m_tuser_d[TUSER_TS_MSB:TUSER_TS_LSB] = ts_q;
            if (s_axis_tlast) begin
              if (n_last <= 4'd2) begin
                m_tkeep_d = keep_mask(4'd6 + n_last);
                m_tlast_d = 1'b1;
                m_tuser_d[TUSER_ERR_BIT] = last_err;
                state_d   = ST_HDR;
              end else begin
                flush_keep_d = keep_mask(n_last - 4'd2);
                flush_err_d  = last_err;
                state_d      = ST_FLUSH;
              end
            end
          end
        end
      end

      ST_FLUSH: begin
        if (out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = {16'h0, hold_q};
          m_tkeep_d  = flush_keep_q;
          m_tlast_d  = 1'b1;
          m_tuser_d  = '0;
          m_tuser_d[TUSER_TS_MSB:TUSER_TS_LSB] = ts_q;
          m_tuser_d[TUSER_ERR_BIT] = flush_err_q;
          state_d    = ST_HDR;
        end
      end

      default: begin
        if (in_hs && s_axis_tlast) begin
          drop_inc = 1'b1;
          state_d  = ST_HDR;
        end
      end
    endcase

    out_last_hs = m_tvalid_q && m_axis_tready && m_tlast_q;
    if (out_last_hs && !m_tuser_q[TUSER_ERR_BIT]) ok_d = ok_q + CNT_WIDTH'(1);
    if (out_last_hs && m_tuser_q[TUSER_ERR_BIT])  err_d = err_q + CNT_WIDTH'(1);
    if (drop_inc) drop_d = drop_q + CNT_WIDTH'(1);
  end

  // State, datapath and counter registers; reset discards any partial output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HDR;
      beat_q       <= '0;
      port_q       <= '0;
      etype_q      <= '0;
      verihl_q     <= '0;
      proto_q      <= '0;
      ts_q         <= '0;
      first_q      <= 1'b0;
      hold_q       <= '0;
      flush_keep_q <= '0;
      flush_err_q  <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tkeep_q    <= '0;
      m_tlast_q    <= 1'b0;
      m_tuser_q    <= '0;
      ok_q         <= '0;
      drop_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      port_q       <= port_d;
      etype_q      <= etype_d;
      verihl_q     <= verihl_d;
      proto_q      <= proto_d;
      ts_q         <= ts_d;
      first_q      <= first_d;
      hold_q       <= hold_d;
      flush_keep_q <= flush_keep_d;
      flush_err_q  <= flush_err_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tkeep_q    <= m_tkeep_d;
      m_tlast_q    <= m_tlast_d;
      m_tuser_q    <= m_tuser_d;
      ok_q         <= ok_d;
      drop_q       <= drop_d;
      err_q        <= err_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign frames_ok     = ok_q;
  assign frames_drop   = drop_q;
  assign frames_err    = err_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Self-checking bench for udp_rx_parser: byte-level frame model and scoreboard.
module tb_udp_rx_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_udp_port;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic [71:0] s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic [71:0] m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] frames_ok, frames_drop, frames_err;

  always #5 clk = ~clk;

  udp_rx_parser dut (
    .clk(clk), .rst(rst), .cfg_udp_port(cfg_udp_port),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .frames_ok(frames_ok), .frames_drop(frames_drop), .frames_err(frames_err)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [71:0] u;
  } beat_t;

  int n_vec = 0;
  int n_err = 0;
  beat_t exp_q[$];
  int exp_ok = 0, exp_drop = 0, exp_err = 0;
  int out_beats = 0;
  int tready_low = 0;
  int rdy_pct = 100;
  int gap_pct = 0;

  logic [7:0]  fr [0:255];
  int          fr_len;
  logic [63:0] fr_ts;
  logic        fr_err;

  // Frame builder: random bytes with a well-formed header, optionally corrupted.
  task automatic make_frame(input int len, input logic [15:0] port, input int bad, input logic err);
    for (int i = 0; i < 256; i++) fr[i] = 8'($urandom);
    fr[12] = 8'h08; fr[13] = 8'h00; fr[14] = 8'h45; fr[23] = 8'h11;
    fr[36] = port[15:8]; fr[37] = port[7:0];
    case (bad)
      1: fr[13] = 8'h06;
      2: fr[14] = 8'h46;
      3: fr[23] = 8'h06;
      4: fr[37] = fr[37] ^ 8'h01;
      default: ;
    endcase
    fr_len = len;
    fr_ts  = {$urandom, $urandom};
    fr_err = err;
  endtask

  // Reference model: payload = frame bytes 42..end, accepted only for a good
  // header on a frame of at least six beats with a non-empty payload.
  task automatic model_frame(input logic [15:0] cfg);
    int nbeats, plen;
    bit ok;
    beat_t e;
    nbeats = (fr_len + 7) / 8;
    ok = (fr[12] == 8'h08) && (fr[13] == 8'h00) && (fr[14] == 8'h45) &&
         (fr[23] == 8'h11) && ({fr[36], fr[37]} == cfg);
    if (nbeats <= 5 || !ok || fr_len <= 42) begin
      exp_drop++;
    end else begin
      plen = fr_len - 42;
      for (int b = 0; b * 8 < plen; b++) begin
        e.d = '0; e.k = '0;
        for (int i = 0; i < 8; i++) begin
          if (b * 8 + i < plen) begin
            e.d[8*i +: 8] = fr[42 + b * 8 + i];
            e.k[i] = 1'b1;
          end
        end
        e.l = (b * 8 + 8 >= plen);
        e.u = {fr_ts, 7'b0, e.l & fr_err};
        exp_q.push_back(e);
      end
      if (fr_err) exp_err++; else exp_ok++;
    end
  endtask

  task automatic send_frame();
    int nb;
    bit hs;
    nb = (fr_len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      for (int i = 0; i < 8; i++) begin
        if (b * 8 + i < fr_len) begin
          s_axis_tdata[8*i +: 8] = fr[b * 8 + i];
          s_axis_tkeep[i] = 1'b1;
        end
      end
      s_axis_tlast = (b == nb - 1);
      s_axis_tuser = {(b == 0) ? fr_ts : {$urandom, $urandom}, 7'($urandom),
                      (b == nb - 1) ? fr_err : 1'($urandom)};
      hs = 1'b0;
      for (int c = 0; c < 200 && !hs; c++) begin
        @(negedge clk);
        hs = s_axis_tready;
        @(posedge clk); #1;
      end
      if (!hs) begin
        n_vec++; n_err++;
        $display("FAIL input_handshake_timeout beat=%0d", b);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !m_axis_tvalid;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Randomised downstream backpressure, changed just after each rising edge.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Output monitor: scoreboard compare on every handshake, stability under stall.
  initial begin
    beat_t e;
    logic [63:0] mask;
    logic [146:0] saved;
    bit stall_prev;
    stall_prev = 1'b0;
    saved = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (!s_axis_tready) tready_low++;
        if (stall_prev) begin
          n_vec++;
          if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== saved) begin
            n_err++;
            $display("FAIL stall_stable got %h required %h",
                     {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, saved);
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        saved = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (m_axis_tvalid && m_axis_tready) begin
          out_beats++;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat got d=%h k=%h l=%b required none",
                     m_axis_tdata, m_axis_tkeep, m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            mask = '0;
            for (int i = 0; i < 8; i++) if (e.k[i]) mask[8*i +: 8] = 8'hFF;
            if ((m_axis_tdata & mask) !== e.d || m_axis_tkeep !== e.k ||
                m_axis_tlast !== e.l || m_axis_tuser !== e.u) begin
              n_err++;
              $display("FAIL out_beat got d=%h k=%h l=%b u=%h required d=%h k=%h l=%b u=%h",
                       m_axis_tdata & mask, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                       e.d, e.k, e.l, e.u);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    cfg_udp_port = 16'd5000;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_axis_tuser = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({m_axis_tvalid, m_axis_tlast} !== 2'b00) begin
      n_err++; $display("FAIL reset_valid_last got %b required 00", {m_axis_tvalid, m_axis_tlast});
    end
    n_vec++;
    if ({m_axis_tdata, m_axis_tkeep, m_axis_tuser} !== '0) begin
      n_err++; $display("FAIL reset_out_regs got %h required 0", {m_axis_tdata, m_axis_tkeep, m_axis_tuser});
    end
    n_vec++;
    if ({frames_ok, frames_drop, frames_err} !== 96'd0) begin
      n_err++; $display("FAIL reset_counters got %h required 0", {frames_ok, frames_drop, frames_err});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (s_axis_tready !== 1'b1) begin
      n_err++; $display("FAIL reset_tready got %b required 1", s_axis_tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_valid_frame();
    int b0;
    rdy_pct = 100; gap_pct = 0;
    cfg_udp_port = 16'd5000;
    b0 = out_beats; tready_low = 0;
    make_frame(58, 16'd5000, 0, 1'b0);
    model_frame(cfg_udp_port);
    send_frame();
    drain();
    n_vec++;
    if (out_beats - b0 !== 2) begin
      n_err++; $display("FAIL valid_beats got %0d required 2", out_beats - b0);
    end
    n_vec++;
    if (frames_ok !== 32'd1) begin
      n_err++; $display("FAIL valid_frames_ok got %0d required 1", frames_ok);
    end
    n_vec++;
    if (tready_low !== 0) begin
      n_err++; $display("FAIL valid_tready_low got %0d required 0", tready_low);
    end
  endtask

  task automatic test_port_mismatch();
    int b0;
    cfg_udp_port = 16'd5001;
    b0 = out_beats; tready_low = 0;
    make_frame(58, 16'd5000, 0, 1'b0);
    model_frame(cfg_udp_port);
    send_frame();
    drain();
    n_vec++;
    if (out_beats - b0 !== 0) begin
      n_err++; $display("FAIL mismatch_beats got %0d required 0", out_beats - b0);
    end
    n_vec++;
    if (tready_low !== 0) begin
      n_err++; $display("FAIL mismatch_tready_low got %0d required 0", tready_low);
    end
    n_vec++;
    if (frames_drop !== 32'd1) begin
      n_err++; $display("FAIL mismatch_frames_drop got %0d required 1", frames_drop);
    end
  endtask

  task automatic test_flush();
    int b0;
    cfg_udp_port = 16'd5000;
    b0 = out_beats; tready_low = 0;
    make_frame(55, 16'd5000, 0, 1'b0);
    model_frame(cfg_udp_port);
    send_frame();
    drain();
    n_vec++;
    if (out_beats - b0 !== 2) begin
      n_err++; $display("FAIL flush_beats got %0d required 2", out_beats - b0);
    end
    n_vec++;
    if (tready_low !== 1) begin
      n_err++; $display("FAIL flush_tready_low got %0d required 1", tready_low);
    end
  endtask

  task automatic test_runt_then_valid();
    int ok0, drop0;
    cfg_udp_port = 16'd5000;
    ok0 = frames_ok; drop0 = frames_drop;
    make_frame(32, 16'd5000, 0, 1'b0);
    model_frame(cfg_udp_port);
    send_frame();
    make_frame(64, 16'd5000, 0, 1'b0);
    model_frame(cfg_udp_port);
    send_frame();
    drain();
    n_vec++;
    if (frames_drop - drop0 !== 1) begin
      n_err++; $display("FAIL runt_drop_delta got %0d required 1", frames_drop - drop0);
    end
    n_vec++;
    if (frames_ok - ok0 !== 1) begin
      n_err++; $display("FAIL runt_ok_delta got %0d required 1", frames_ok - ok0);
    end
  endtask

  task automatic test_error_flag();
    int ok0, err0;
    cfg_udp_port = 16'd5000;
    ok0 = frames_ok; err0 = frames_err;
    make_frame(70, 16'd5000, 0, 1'b1);
    model_frame(cfg_udp_port);
    send_frame();
    drain();
    n_vec++;
    if (frames_err - err0 !== 1) begin
      n_err++; $display("FAIL err_err_delta got %0d required 1", frames_err - err0);
    end
    n_vec++;
    if (frames_ok - ok0 !== 0) begin
      n_err++; $display("FAIL err_ok_delta got %0d required 0", frames_ok - ok0);
    end
  endtask

  task automatic test_back_to_back();
    int len, bad;
    logic [15:0] port;
    rdy_pct = 50;
    for (int f = 0; f < 30; f++) begin
      gap_pct = (f % 2 == 0) ? 0 : 20;
      len  = $urandom_range(30, 130);
      if (f % 7 == 3) len = 41 + (f % 2);
      bad  = ($urandom_range(9) < 3) ? $urandom_range(1, 4) : 0;
      port = 16'($urandom);
      cfg_udp_port = port;
      make_frame(len, port, bad, 1'($urandom_range(3) == 0));
      model_frame(cfg_udp_port);
      send_frame();
    end
    drain();
    rdy_pct = 100; gap_pct = 0;
    n_vec++;
    if (frames_ok !== 32'(exp_ok)) begin
      n_err++; $display("FAIL b2b_frames_ok got %0d required %0d", frames_ok, exp_ok);
    end
    n_vec++;
    if (frames_drop !== 32'(exp_drop)) begin
      n_err++; $display("FAIL b2b_frames_drop got %0d required %0d", frames_drop, exp_drop);
    end
    n_vec++;
    if (frames_err !== 32'(exp_err)) begin
      n_err++; $display("FAIL b2b_frames_err got %0d required %0d", frames_err, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_port_mismatch();
    test_flush();
    test_runt_then_valid();
    test_error_flag();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/udp_rx_parser.md
# udp_rx_parser

Sits directly downstream of the MAC-side async FIFO in the core clock domain and consumes its 64-bit AXI-Stream Ethernet frames. It checks the IPv4 and UDP headers against the configured destination port and drops non-matching frames. For matching frames it strips the 42-byte Eth/IPv4/UDP header and emits the UDP payload re-aligned to byte 0, carrying the ingress timestamp and error flag on tuser.

## Interface
- USER_WIDTH, 72, tuser width. Layout: [0] frame error, valid on tlast beat; [7:1] reserved, driven 0; [71:8] 64-bit ingress timestamp, valid on first beat.
- CNT_WIDTH, 32, width of the statistics counters. Counters wrap.
- clk  in  1  core clock
- rst  in  1  reset, asynchronous and active-high
- cfg_udp_port  in  16  UDP destination port to accept. Sampled at frame start.
- s_axis_tdata/tkeep/tlast/tuser/tvalid  in  64/8/1/72/1  frame input. Byte n of a beat is tdata[8n+7:8n]. Wire bytes are big-endian within fields.
- s_axis_tready  out  1
- m_axis_tdata/tkeep/tlast/tuser/tvalid  out  64/8/1/72/1  payload output
- m_axis_tready  in  1
- frames_ok, frames_drop, frames_err  out  CNT_WIDTH each  statistics counters

## Operation
- Input beats are numbered k = 0, 1, … per frame.
- **Header checks**, all required for a frame to be accepted:
  - Ethertype (bytes 12–13) = 0x0800.
  - Version/IHL (byte 14) = 0x45.
  - Protocol (byte 23) = 0x11.
  - UDP destination port (bytes 36–37) = cfg_udp_port.
- **State HDR:** s_axis_tready = 1. Fields are latched as their beats arrive. The decision is made on the beat-4 handshake.
  - Pass → PAYLOAD.
  - Fail → DROP.
  - tlast on beat ≤ 4 (runt) → frames_drop++, stay in HDR.
  - tuser[71:8] of beat 0 is latched as the timestamp.
- **State PAYLOAD:** payload starts at byte 2 of beat 5.
  - A 6-byte holding register keeps input bytes 2–7 of the previous beat.
  - Output beat = {current input bytes 0–1, hold bytes 0–5}. The first output is produced on the beat-6 handshake.
  - On input tlast, let n = number of valid bytes in the last beat (tkeep contiguous from bit 0).
    - n ≤ 2: the output beat is final. tkeep = 6 held bytes + n → HDR.
    - n > 2: emit the combined full beat, then → FLUSH with the remaining n−2 bytes.
    - tlast on beat 5: payload = n−2 bytes at byte 0, emitted as the final beat. If n ≤ 2 (empty payload) → no output, frames_drop++.
- **State FLUSH:** s_axis_tready = 0. Emit the held remainder with tlast → HDR.
- **State DROP:** s_axis_tready = 1. Discard beats until tlast → HDR, frames_drop++.
- **Output tuser:** [71:8] = latched timestamp on every beat. [0] = input tuser[0] of the tlast beat, on the output tlast beat only. [0] = 0 elsewhere. [7:1] = 0.
- **Counters:**
  - frames_ok++ on an output tlast handshake with tuser[0] = 0.
  - frames_err++ on an output tlast handshake with tuser[0] = 1.
  - frames_drop++ as listed above.
  - Simultaneous increments of different counters are independent.

## Timing
- The output is a single register stage. A beat appears the cycle after the input handshake that completes it.
- In PAYLOAD, s_axis_tready = !m_axis_tvalid || m_axis_tready. This gives full throughput with no bubbles and no combinational path from tvalid to tready.
- m_axis data/tkeep/tlast/tuser hold stable while tvalid && !tready.
- A frame whose first beat arrives directly after a FLUSH is accepted without an idle cycle, because FLUSH lasts exactly one output handshake.
- **Reset values:**
  - m_axis_tvalid = 0, m_axis_tdata/tkeep/tlast/tuser = 0.
  - s_axis_tready = 1 once rst deasserts.
  - All counters = 0, state = HDR.
- **Reset mid-frame:** rst returns immediately to HDR and discards partial output. The upstream FIFO is reset in the same reset tree, so no frame resynchronisation is required.

## Structure
- Shared package eth_pkg holds:
  - ETHERTYPE_IPV4, IP_PROTO_UDP, IPV4_VER_IHL.
  - Header byte offsets and HDR_LEN = 42.
  - tuser bit positions (TUSER_ERR_BIT, TUSER_TS_LSB/MSB).
  - The parser state enum.
- No sub-module. The realign datapath and counters are inline, at about 250 lines.

## Test plan
- Valid frame, port 5000, 16-byte payload (8 input beats, last tkeep 0x03) → 2 output beats with tkeep 0xFF, 0xFF; tlast on the 2nd; tuser[71:8] = beat-0 timestamp; frames_ok = 1.
- Same frame with cfg_udp_port = 5001 → no output, s_axis_tready high throughout, frames_drop = 1.
- 13-byte payload (7 beats, last tkeep 0x7F) → output 0xFF beat (bytes 42–49), then FLUSH beat tkeep 0x1F (bytes 50–54) tlast; s_axis_tready = 0 during FLUSH.
- Back-to-back valid frames with m_axis_tready random 50% → payload bytes match the model exactly, with no loss or duplication; outputs stable while stalled.
- 4-beat runt, then a valid frame → runt dropped (frames_drop = 1), second frame parsed correctly.
- Valid frame with input tuser[0] = 1 on tlast → payload forwarded, output tlast beat has tuser[0] = 1, frames_err = 1, frames_ok = 0.
